indicator_ctrl: RTL and testbench
=================================

INDICATOR_CTRL -- requirements
Module: indicator_ctrl

Interface
REQ-001 Parameter COL_X0, default 24: x pixel of column 0 indicator.
REQ-002 Parameter COL_PITCH, default 16: x pixels between columns.
REQ-003 Parameter IND_Y0, default 11: y pixel of the resting indicator.
REQ-004 Parameter ROW_Y0, default 24: landing y of row 0; ROW_PITCH, default 16: y pixels between rows.
REQ-005 Parameter FALL_STEP, default 2: y pixels moved per frame during the drop animation.
REQ-006 One clock and one reset: the clock is clk; the reset is rst_n, synchronous and active-low.
REQ-007 Ports, in the form name direction width meaning:
- clk in 1: clock.
- rst_n in 1: synchronous active-low reset.
- frameTick in 1: one-cycle pulse, once per video frame.
- btnLeft in 1: one-cycle pulse, move left.
- btnRight in 1: one-cycle pulse, move right.
- btnDrop in 1: one-cycle pulse, drop a piece.
- colFull in 7: bit i set means column i is full.
- gameOver in 1: the board reports a win.
- dropReady in 1: the board accepts the drop.
- landRow in 3: landing row, valid with dropReady.
- dropValid out 1: drop request.
- dropCol out 3: column of the drop request.
- placeDone out 1: one-cycle pulse when the animation ends.
- indX out 10: indicator x pixel.
- indY out 10: indicator y pixel.
- indVisible out 1: the sprite layer enable.
- player out 1: 0 = red, 1 = yellow.

Function
REQ-008 The FSM states SHALL be SELECT, REQUEST, ANIMATE and LOCKED, and all outputs SHALL be registered.
REQ-009 In SELECT, btnDrop SHALL take priority over the move buttons. On btnDrop: dropValid=1, dropCol=col, and the next state is REQUEST.
REQ-010 In SELECT, btnLeft and btnRight asserted together SHALL be ignored.
REQ-011 On btnLeft alone, col SHALL move to the nearest non-full column in descending order, wrapping from 0 to 6. btnRight is the mirror case, wrapping from 6 to 0. If no other column is free, col stays unchanged.
REQ-012 Buttons SHALL be ignored in every state except SELECT.
REQ-013 indX SHALL equal COL_X0 + col*COL_PITCH and SHALL update in the same cycle as col.
REQ-014 In REQUEST, dropValid and dropCol SHALL stay stable until the cycle in which dropReady=1.
- In that cycle: capture target = ROW_Y0 + min(landRow,5)*ROW_PITCH, drop dropValid, and go to ANIMATE.
- dropReady while dropValid=0 is ignored.
REQ-015 In ANIMATE, on each frameTick, indY SHALL become min(indY+FALL_STEP, target).
REQ-016 In the cycle after indY reaches target, the block SHALL:
- pulse placeDone for one cycle;
- toggle player;
- set indY=IND_Y0;
- set col to the first non-full column scanning upward from col with wrap-around;
- return to SELECT.
REQ-017 If all 7 colFull bits are set when leaving ANIMATE, the next state SHALL be LOCKED instead of SELECT.
REQ-018 gameOver SHALL be sampled only in SELECT, where gameOver=1 moves the FSM to LOCKED on the next edge; in ANIMATE the animation completes first.
REQ-019 LOCKED SHALL be exited only by reset. In LOCKED, indVisible=0 and dropValid=0.
REQ-020 In SELECT, indVisible SHALL toggle every 16 frameTicks, driven by a 4-bit blink counter that wraps.
REQ-021 In REQUEST and ANIMATE, indVisible SHALL be 1 and the blink counter SHALL hold.

Reset
REQ-022 While rst_n=0 at a clk edge, the outputs and state SHALL take these values:
- state=SELECT, col=3;
- indX=72, indY=11, indVisible=1;
- player=0, dropValid=0, dropCol=3, placeDone=0;
- blink counter=0, target=0.
REQ-023 A reset during REQUEST or ANIMATE SHALL abandon the request or animation with no placeDone pulse.

Structure
REQ-024 The layout constants (column count 7, row count 6, pitches, origins) and the state encoding SHALL live in the shared package connect4_pkg.
REQ-025 The wrap-around search for a free column SHALL be one combinational sub-module, next_free_col, with inputs start and dir and the colFull mask, and outputs col and found.

Verification
REQ-026 Reset, then btnRight three times with colFull=0 -> col 6, indX=120; then btnRight -> col 0, indX=24.
REQ-027 colFull=7'b0010100 with col=1, then btnRight -> col 3; btnLeft and btnRight in the same cycle -> col unchanged.
REQ-028 btnDrop at col 3 with dropReady held 0 for 5 cycles -> dropValid stays 1 and dropCol=3; dropReady=1 with landRow=5 -> ANIMATE, target 104.
REQ-029 Animation 11->104 with step 2 -> 47 frameTicks to reach target; then placeDone pulses once, player=1, indY=11.
REQ-030 gameOver=1 in SELECT -> LOCKED, indVisible=0, btnDrop ignored. The last drop filling all columns -> LOCKED after placeDone.
REQ-031 rst_n=0 mid-ANIMATE -> next cycle shows the reset values, with no placeDone.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared board geometry, indicator layout defaults and FSM encoding for the
// Connect-4 front end.
package connect4_pkg;
  localparam int NUM_COLS       = 7;
  localparam int NUM_ROWS       = 6;
  localparam int COL_X0_DEF     = 24;
  localparam int COL_PITCH_DEF  = 16;
  localparam int IND_Y0_DEF     = 11;
  localparam int ROW_Y0_DEF     = 24;
  localparam int ROW_PITCH_DEF  = 16;
  localparam int FALL_STEP_DEF  = 2;
  localparam logic [2:0] START_COL = 3'd3;

  typedef enum logic [1:0] {SELECT, REQUEST, ANIMATE, LOCKED} state_t;

  function automatic logic [2:0] col_inc(input logic [2:0] c);
    return (c == 3'(NUM_COLS - 1)) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [2:0] col_dec(input logic [2:0] c);
    return (c == 3'd0) ? 3'(NUM_COLS - 1) : c - 3'd1;
  endfunction
endpackage

// File: rtl/next_free_col.sv
// Wrap-around search for the first non-full column, starting at (and
// including) start, scanning upward (dir=0) or downward (dir=1).
module next_free_col
  import connect4_pkg::*;
(
  input  logic [2:0]          start,
  input  logic                dir,
  input  logic [NUM_COLS-1:0] colFull,
  output logic [2:0]          col,
  output logic                found
);
  logic [3:0] s;

  always_comb begin
    col   = start;
    found = 1'b0;
    s     = '0;
    // Walk from farthest to nearest so the nearest free column wins.
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      s = {1'b0, start} + (dir ? 4'(NUM_COLS - k) : 4'(k));
      if (s >= 4'(NUM_COLS)) s = s - 4'(NUM_COLS);
      if (!colFull[s[2:0]]) begin
        col   = s[2:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/indicator_ctrl.sv
// Column-select indicator: moves over free columns, issues drop requests,
// animates the falling piece and alternates players.
module indicator_ctrl
  import connect4_pkg::*;
#(
  parameter int COL_X0    = COL_X0_DEF,
  parameter int COL_PITCH = COL_PITCH_DEF,
  parameter int IND_Y0    = IND_Y0_DEF,
  parameter int ROW_Y0    = ROW_Y0_DEF,
  parameter int ROW_PITCH = ROW_PITCH_DEF,
  parameter int FALL_STEP = FALL_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frameTick,
  input  logic                btnLeft,
  input  logic                btnRight,
  input  logic                btnDrop,
  input  logic [NUM_COLS-1:0] colFull,
  input  logic                gameOver,
  input  logic                dropReady,
  input  logic [2:0]          landRow,
  output logic                dropValid,
  output logic [2:0]          dropCol,
  output logic                placeDone,
  output logic [9:0]          indX,
  output logic [9:0]          indY,
  output logic                indVisible,
  output logic                player
);
  state_t     state;
  logic [2:0] col;
  logic [3:0] blink;
  logic [9:0] target;

  logic [2:0]  srch_start, srch_col;
  logic        srch_dir, srch_found, move;
  logic [10:0] y_step;
  logic [9:0]  y_next;
  logic [2:0]  land_clamped;

  function automatic logic [9:0] col_x(input logic [2:0] c);
    return 10'(COL_X0 + int'(c) * COL_PITCH);
  endfunction

  assign move         = btnLeft ^ btnRight;
  assign y_step       = {1'b0, indY} + 11'(FALL_STEP);
  assign y_next       = (y_step >= {1'b0, target}) ? target : y_step[9:0];
  assign land_clamped = (landRow > 3'(NUM_ROWS - 1)) ? 3'(NUM_ROWS - 1) : landRow;

  // Moves search from the neighbour; the post-drop settle includes col itself.
  always_comb begin
    srch_dir   = 1'b0;
    srch_start = col;
    if (state == SELECT) begin
      srch_dir   = btnLeft;
      srch_start = btnLeft ? col_dec(col) : col_inc(col);
    end
  end

  next_free_col u_search (
    .start   (srch_start),
    .dir     (srch_dir),
    .colFull (colFull),
    .col     (srch_col),
    .found   (srch_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SELECT;
      col        <= START_COL;
      indX       <= col_x(START_COL);
      indY       <= 10'(IND_Y0);
      indVisible <= 1'b1;
      player     <= 1'b0;
      dropValid  <= 1'b0;
      dropCol    <= START_COL;
      placeDone  <= 1'b0;
      blink      <= '0;
      target     <= '0;
    end else begin
      placeDone <= 1'b0;
      case (state)
        SELECT: begin
          if (gameOver) begin
            state      <= LOCKED;
            indVisible <= 1'b0;
            dropValid  <= 1'b0;
          end else if (btnDrop) begin
            dropValid  <= 1'b1;
            dropCol    <= col;
            indVisible <= 1'b1;
            state      <= REQUEST;
          end else begin
            if (move && srch_found) begin
              col  <= srch_col;
              indX <= col_x(srch_col);
            end
            if (frameTick) begin
              blink <= blink + 4'd1;
              if (blink == 4'hf) indVisible <= ~indVisible;
            end
          end
        end
        REQUEST: begin
          if (dropReady) begin
            target    <= 10'(ROW_Y0 + int'(land_clamped) * ROW_PITCH);
            dropValid <= 1'b0;
            state     <= ANIMATE;
          end
        end
        ANIMATE: begin
          if (indY == target) begin
            placeDone <= 1'b1;
            player    <= ~player;
            indY      <= 10'(IND_Y0);
            if (srch_found) begin
              col   <= srch_col;
              indX  <= col_x(srch_col);
              state <= SELECT;
            end else begin
              indVisible <= 1'b0;
              state      <= LOCKED;
            end
          end else if (frameTick) begin
            indY <= y_next;
          end
        end
        default: begin
          indVisible <= 1'b0;
          dropValid  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_indicator_ctrl.sv
// Directed plus randomized bench for indicator_ctrl with a behavioural model.
module tb_indicator_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frameTick = 1'b0, btnLeft = 1'b0, btnRight = 1'b0, btnDrop = 1'b0;
  logic       gameOver = 1'b0, dropReady = 1'b0;
  logic [6:0] colFull = '0;
  logic [2:0] landRow = '0;
  logic       dropValid, placeDone, indVisible, player;
  logic [2:0] dropCol;
  logic [9:0] indX, indY;

  int checks = 0, errors = 0;

  localparam int S_SEL = 0, S_REQ = 1, S_ANI = 2, S_LCK = 3;
  int m_st, m_col, m_y, m_tgt, m_ticks, m_dcol;
  bit m_vis, m_pl, m_dv, m_pd;

  always #5 clk = ~clk;

  indicator_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frameTick(frameTick), .btnLeft(btnLeft),
    .btnRight(btnRight), .btnDrop(btnDrop), .colFull(colFull), .gameOver(gameOver),
    .dropReady(dropReady), .landRow(landRow), .dropValid(dropValid), .dropCol(dropCol),
    .placeDone(placeDone), .indX(indX), .indY(indY), .indVisible(indVisible), .player(player)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nearest free column k steps away (k=1..6), or -1 when none.
  function automatic int find_move(int c, bit right, logic [6:0] full);
    for (int k = 1; k < 7; k++) begin
      int n = right ? (c + k) % 7 : (c + 7 - k) % 7;
      if (!full[n]) return n;
    end
    return -1;
  endfunction

  function automatic int find_settle(int c, logic [6:0] full);
    for (int k = 0; k < 7; k++)
      if (!full[(c + k) % 7]) return (c + k) % 7;
    return -1;
  endfunction

  task automatic model_step();
    int c;
    m_pd = 0;
    if (!rst_n) begin
      m_st = S_SEL; m_col = 3; m_y = 11; m_vis = 1; m_pl = 0;
      m_dv = 0; m_dcol = 3; m_ticks = 0; m_tgt = 0;
      return;
    end
    case (m_st)
      S_SEL:
        if (gameOver) begin m_st = S_LCK; m_vis = 0; m_dv = 0; end
        else if (btnDrop) begin m_dv = 1; m_dcol = m_col; m_vis = 1; m_st = S_REQ; end
        else begin
          if (btnLeft != btnRight) begin
            c = find_move(m_col, btnRight, colFull);
            if (c >= 0) m_col = c;
          end
          if (frameTick) begin
            m_ticks++;
            if (m_ticks % 16 == 0) m_vis = !m_vis;
          end
        end
      S_REQ:
        if (dropReady) begin
          m_tgt = 24 + ((landRow > 5) ? 5 : int'(landRow)) * 16;
          m_dv = 0; m_st = S_ANI;
        end
      S_ANI:
        if (m_y == m_tgt) begin
          m_pd = 1; m_pl = !m_pl; m_y = 11;
          c = find_settle(m_col, colFull);
          if (c >= 0) begin m_col = c; m_st = S_SEL; end
          else begin m_st = S_LCK; m_vis = 0; end
        end else if (frameTick) m_y = (m_y + 2 > m_tgt) ? m_tgt : m_y + 2;
      default: begin m_vis = 0; m_dv = 0; end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("dropValid", dropValid, m_dv);
    chk("dropCol", dropCol, m_dcol);
    chk("placeDone", placeDone, m_pd);
    chk("indX", indX, 24 + 16 * m_col);
    chk("indY", indY, m_y);
    chk("indVisible", indVisible, m_vis);
    chk("player", player, m_pl);
    frameTick = 0; btnLeft = 0; btnRight = 0; btnDrop = 0;
  endtask

  initial begin
    int n;
    // Reset state
    rst_n = 0; cyc(); cyc(); rst_n = 1;
    chk("rst_indX", indX, 72); chk("rst_indY", indY, 11); chk("rst_vis", indVisible, 1);
    chk("rst_dv", dropValid, 0); chk("rst_dcol", dropCol, 3); chk("rst_player", player, 0);

    // Right moves with wrap
    for (int i = 0; i < 3; i++) begin btnRight = 1; cyc(); end
    chk("right3_indX", indX, 120);
    btnRight = 1; cyc(); chk("wrap_indX", indX, 24);

    // Skip full columns, ignore both buttons
    colFull = 7'b0010100;
    btnRight = 1; cyc(); chk("col1_indX", indX, 40);
    btnRight = 1; cyc(); chk("skip_indX", indX, 72);
    btnLeft = 1; btnRight = 1; cyc(); chk("both_indX", indX, 72);
    btnLeft = 1; cyc(); chk("left_skip_indX", indX, 40);
    btnRight = 1; cyc();

    // Drop request held until dropReady
    colFull = '0;
    btnDrop = 1; cyc(); chk("req_dv", dropValid, 1);
    for (int i = 0; i < 5; i++) begin
      btnLeft = 1; cyc(); chk("hold_dv", dropValid, 1); chk("hold_dcol", dropCol, 3);
    end
    dropReady = 1; landRow = 5; cyc(); dropReady = 0;
    chk("ack_dv", dropValid, 0);

    // Animation 11 -> 104
    n = 0;
    for (int i = 0; i < 100 && indY != 104; i++) begin
      frameTick = 1; cyc(); n++;
      if (indY != 104) cyc();
    end
    chk("fall_ticks", n, 47);
    cyc();
    chk("done_pulse", placeDone, 1); chk("done_player", player, 1); chk("done_indY", indY, 11);
    cyc(); chk("done_once", placeDone, 0);

    // Blink after 16 ticks in SELECT
    for (int i = 0; i < 15; i++) begin frameTick = 1; cyc(); end
    chk("blink15", indVisible, 1);
    frameTick = 1; cyc(); chk("blink16", indVisible, 0);

    // Reset mid-animation
    btnDrop = 1; cyc();
    dropReady = 1; landRow = 0; cyc(); dropReady = 0;
    for (int i = 0; i < 3; i++) begin frameTick = 1; cyc(); end
    rst_n = 0; cyc(); rst_n = 1;
    chk("midrst_pd", placeDone, 0); chk("midrst_indY", indY, 11);
    chk("midrst_indX", indX, 72); chk("midrst_player", player, 0);
    cyc(); chk("midrst_pd2", placeDone, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 64 == 0) colFull = 7'($urandom & $urandom & $urandom);
      frameTick = 1'($urandom % 2);
      btnLeft   = ($urandom % 4 == 0);
      btnRight  = ($urandom % 4 == 0);
      btnDrop   = ($urandom % 16 == 0);
      dropReady = ($urandom % 4 == 0);
      landRow   = 3'($urandom);
      cyc();
    end
    dropReady = 0; colFull = '0;
    rst_n = 0; cyc(); rst_n = 1;

    // gameOver locks
    gameOver = 1; cyc(); gameOver = 0;
    chk("go_vis", indVisible, 0);
    btnDrop = 1; cyc(); chk("go_drop", dropValid, 0);
    rst_n = 0; cyc(); rst_n = 1;

    // Last drop fills the board
    colFull = 7'b1110111;
    btnDrop = 1; cyc();
    dropReady = 1; landRow = 0; cyc(); dropReady = 0;
    colFull = 7'h7f;
    for (int i = 0; i < 40 && indY != 24; i++) begin frameTick = 1; cyc(); end
    chk("full_reach", indY, 24);
    cyc(); chk("full_pd", placeDone, 1); chk("full_vis", indVisible, 0);
    btnDrop = 1; cyc(); chk("full_drop", dropValid, 0);
    frameTick = 1; cyc(); chk("full_vis2", indVisible, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
